mc_ecc_fi_ctrl: RTL and testbench

MC_ECC_FI_CTRL -- requirements
Module: mc_ecc_fi_ctrl

---
 rtl/mc_ecc_fi_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mc_ecc_fi_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ecc_fi_ctrl.sv
// ECC fault-injection controller.
// Loads an XOR pattern into the write-path fault-injection datapath only while
// the write path is quiet. It counts the injections that writes consume, inserts
// clean-write gaps between injections, and clears the datapath when a job is
// aborted with an injection still armed.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no job; cfg_ready high, accepts a new job
//  ARM     | waiting for a quiet write path to load pattern (one-cycle strobe)
//  WAIT_WR | pattern loaded; waiting for the write that consumes it
//  GAP     | counting clean writes before re-arming
//  CLEAR   | abort with pattern loaded; zero the datapath once quiet
module mc_ecc_fi_ctrl #(
    parameter int DQ_WIDTH  = 72,
    parameter int DQS_WIDTH = 9,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DQ_WIDTH-1:0]  cfg_pattern,
    input  logic [DQS_WIDTH-1:0] cfg_byte_en,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [CNT_WIDTH-1:0] cfg_gap,
    input  logic                 abort,
    input  logic                 wrdata_en,
    output logic [DQS_WIDTH-1:0] fi_xor_we,
    output logic [DQ_WIDTH-1:0]  fi_xor_wrdata,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] inj_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT_WR = 3'd2,
        GAP     = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 wd1;
    logic                 wd2;
    logic                 quiet;

    logic [DQ_WIDTH-1:0]  pat_q;
    logic [DQS_WIDTH-1:0] ben_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] gap_q;

    logic [CNT_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] gap_cnt_nxt;
    logic [CNT_WIDTH-1:0] gap_plus1;

    logic [CNT_WIDTH-1:0] inj_cnt_q;
    logic [CNT_WIDTH-1:0] inj_cnt_nxt;
    logic [CNT_WIDTH-1:0] inj_sat_inc;
    logic [CNT_WIDTH:0]   inj_plus1;
    logic                 last_inj;

    logic                 busy_q;
    logic                 done_q;
    logic                 done_nxt;
    logic                 accept;

    // The datapath is still applying a previous write for two cycles after
    // wrdata_en; it may only be reloaded when none of the three is active.
    assign quiet = ~wrdata_en & ~wd1 & ~wd2;

    assign accept      = cfg_valid & (state == IDLE);
    assign gap_plus1   = gap_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign inj_sat_inc = (inj_cnt_q == {CNT_WIDTH{1'b1}}) ? inj_cnt_q
                       : inj_cnt_q + {{(CNT_WIDTH-1){1'b1 & 1'b0}}, 1'b1};
    // Extra bit keeps the "last injection" compare honest once inj_cnt saturates.
    assign inj_plus1   = {1'b0, inj_cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign last_inj    = (cnt_q != '0) && (inj_plus1 == {1'b0, cnt_q});

    assign busy    = busy_q;
    assign done    = done_q;
    assign inj_cnt = inj_cnt_q;

    // Next-state decode and datapath strobe generation.
    always_comb begin
        state_nxt     = state;
        gap_cnt_nxt   = gap_cnt;
        inj_cnt_nxt   = inj_cnt_q;
        done_nxt      = 1'b0;
        cfg_ready     = 1'b0;
        fi_xor_we     = '0;
        fi_xor_wrdata = '0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    state_nxt   = ARM;
                    inj_cnt_nxt = '0;
                end
            end
            ARM: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (quiet) begin
                    fi_xor_we     = ben_q;
                    fi_xor_wrdata = pat_q;
                    state_nxt     = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (wrdata_en) begin
                    // The consuming write also clears the datapath, so an abort
                    // landing on this cycle needs no CLEAR pass.
                    inj_cnt_nxt = inj_sat_inc;
                    if (abort || last_inj) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (gap_q == '0) begin
                        state_nxt = ARM;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = '0;
                    end
                end else if (abort) begin
                    state_nxt = CLEAR;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (wrdata_en) begin
                    gap_cnt_nxt = gap_plus1;
                    if (gap_plus1 == gap_q) begin
                        state_nxt = ARM;
                    end
                end
            end
            CLEAR: begin
                if (quiet) begin
                    fi_xor_we = '1;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters, write-enable history and latched job configuration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wd1       <= 1'b0;
            wd2       <= 1'b0;
            pat_q     <= '0;
            ben_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            inj_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wd1       <= wrdata_en;
            wd2       <= wd1;
            gap_cnt   <= gap_cnt_nxt;
            inj_cnt_q <= inj_cnt_nxt;
            busy_q    <= (state_nxt != IDLE);
            done_q    <= done_nxt;
            if (accept) begin
                pat_q <= cfg_pattern;
                ben_q <= cfg_byte_en;
                cnt_q <= cfg_count;
                gap_q <= cfg_gap;
            end
        end
    end

endmodule

// File: tb/tb_mc_ecc_fi_ctrl.sv
// Directed bench for mc_ecc_fi_ctrl: single shot, write blocking, gapped
// repeats, aborts, continuous mode, ignored requests and mid-job reset.
module tb_mc_ecc_fi_ctrl;

    localparam int DQ  = 72;
    localparam int DQS = 9;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [DQ-1:0]  cfg_pattern = '0;
    logic [DQS-1:0] cfg_byte_en = '0;
    logic [CW-1:0]  cfg_count = '0;
    logic [CW-1:0]  cfg_gap = '0;
    logic           abort = 1'b0;
    logic           wrdata_en = 1'b0;
    logic [DQS-1:0] fi_xor_we;
    logic [DQ-1:0]  fi_xor_wrdata;
    logic           busy;
    logic           done;
    logic [CW-1:0]  inj_cnt;

    int n_chk = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int viol_cnt = 0;
    int strobe_base;
    int done_base;
    int exp_inj[7] = '{1, 1, 1, 2, 2, 2, 3};

    mc_ecc_fi_ctrl #(.DQ_WIDTH(DQ), .DQS_WIDTH(DQS), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pattern   (cfg_pattern),
        .cfg_byte_en   (cfg_byte_en),
        .cfg_count     (cfg_count),
        .cfg_gap       (cfg_gap),
        .abort         (abort),
        .wrdata_en     (wrdata_en),
        .fi_xor_we     (fi_xor_we),
        .fi_xor_wrdata (fi_xor_wrdata),
        .busy          (busy),
        .done          (done),
        .inj_cnt       (inj_cnt)
    );

    always #5 clk = ~clk;

    // Running tallies of strobes, done pulses and datapath-rule violations.
    always @(negedge clk) begin
        if (fi_xor_we != '0) strobe_cnt++;
        if (done) done_cnt++;
        if (fi_xor_we == '0 && fi_xor_wrdata != '0) viol_cnt++;
        if (fi_xor_we != '0 && wrdata_en) viol_cnt++;
    end

    task automatic chk(input string tag, input logic [DQ-1:0] obs, input logic [DQ-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk_cyc();
    endtask

    // Presents a job for one accepted cycle; returns in the first ARM cycle.
    task automatic start_job(input logic [DQ-1:0] p, input logic [DQS-1:0] b,
                             input logic [CW-1:0] c, input logic [CW-1:0] g);
        int k;
        k = 0;
        while (!cfg_ready && k < 20) begin
            clk_cyc();
            k++;
        end
        if (!cfg_ready) chk("cfg_ready_wait", cfg_ready, 1);
        cfg_pattern = p;
        cfg_byte_en = b;
        cfg_count   = c;
        cfg_gap     = g;
        cfg_valid   = 1'b1;
        clk_cyc();
        cfg_valid   = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_we", fi_xor_we, 0);
        chk("rst_wd", fi_xor_wrdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inj", inj_cnt, 0);
        clk_cyc();
        rst = 1'b1;
        clk_cyc();
        @(negedge clk);
        chk("rst_ready", cfg_ready, 1);
        clk_cyc();
        idle(2);

        // Single shot
        start_job(72'h01, 9'h001, 16'd1, 16'd0);
        @(negedge clk);
        chk("t1_we", fi_xor_we, 9'h001);
        chk("t1_wd", fi_xor_wrdata, 72'h01);
        chk("t1_busy", busy, 1);
        chk("t1_ready", cfg_ready, 0);
        clk_cyc();
        wrdata_en = 1'b1;
        @(negedge clk);
        chk("t1_we_off", fi_xor_we, 0);
        clk_cyc();
        wrdata_en = 1'b0;
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_inj", inj_cnt, 1);
        chk("t1_busy_off", busy, 0);
        chk("t1_ready_back", cfg_ready, 1);
        clk_cyc();
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        clk_cyc();
        idle(3);

        // Blocking: write path busy for 4 cycles including the accept cycle
        wrdata_en = 1'b1;
        start_job(72'hFF00, 9'h006, 16'd1, 16'd0);
        for (int i = 0; i < 6; i++) begin
            wrdata_en = (i < 3);
            @(negedge clk);
            chk($sformatf("t2_we_c%0d", i), fi_xor_we, (i == 5) ? 9'h006 : 9'h000);
            if (i == 5) chk("t2_wd", fi_xor_wrdata, 72'hFF00);
            clk_cyc();
        end
        wrdata_en = 1'b1;
        @(negedge clk);
        clk_cyc();
        wrdata_en = 1'b0;
        @(negedge clk);
        chk("t2_done", done, 1);
        chk("t2_inj", inj_cnt, 1);
        clk_cyc();
        idle(3);

        // Repeat with gap: count=3, gap=2, write every 5 cycles
        strobe_base = strobe_cnt;
        done_base   = done_cnt;
        start_job(72'h3_0000_0000, 9'h010, 16'd3, 16'd2);
        @(negedge clk);
        clk_cyc();
        for (int w = 0; w < 7; w++) begin
            wrdata_en = 1'b1;
            @(negedge clk);
            clk_cyc();
            wrdata_en = 1'b0;
            @(negedge clk);
            chk($sformatf("t3_inj_w%0d", w + 1), inj_cnt, exp_inj[w]);
            chk($sformatf("t3_done_w%0d", w + 1), done, (w == 6) ? 1 : 0);
            clk_cyc();
            idle(3);
        end
        chk("t3_strobes", strobe_cnt - strobe_base, 3);
        chk("t3_dones", done_cnt - done_base, 1);
        chk("t3_busy", busy, 0);

        // Abort while armed: CLEAR waits for quiet, then zeroes all lanes
        start_job(72'h5A, 9'h0F0, 16'd1, 16'd0);
        @(negedge clk);
        chk("t4_we", fi_xor_we, 9'h0F0);
        clk_cyc();
        abort = 1'b1;
        @(negedge clk);
        clk_cyc();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wrdata_en = (i == 0);
            @(negedge clk);
            chk($sformatf("t4_clr_c%0d", i), fi_xor_we, (i == 3) ? 9'h1FF : 9'h000);
            chk($sformatf("t4_clr_wd%0d", i), fi_xor_wrdata, 0);
            chk($sformatf("t4_clr_done%0d", i), done, 0);
            clk_cyc();
        end
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_inj", inj_cnt, 0);
        chk("t4_busy", busy, 0);
        clk_cyc();
        idle(3);

        // Continuous: 10 writes, no done, then abort from ARM
        done_base = done_cnt;
        start_job(72'h80, 9'h001, 16'd0, 16'd0);
        @(negedge clk);
        clk_cyc();
        for (int w = 0; w < 10; w++) begin
            wrdata_en = 1'b1;
            @(negedge clk);
            clk_cyc();
            wrdata_en = 1'b0;
            if (w < 9) idle(4);
        end
        @(negedge clk);
        chk("t5_inj", inj_cnt, 10);
        chk("t5_busy", busy, 1);
        clk_cyc();
        chk("t5_no_done", done_cnt - done_base, 0);
        abort = 1'b1;
        @(negedge clk);
        clk_cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("t5_done", done, 1);
        chk("t5_busy_off", busy, 0);
        chk("t5_inj_hold", inj_cnt, 10);
        clk_cyc();
        idle(3);

        // Abort on the consuming write: counted, no CLEAR
        strobe_base = strobe_cnt;
        start_job(72'h02, 9'h001, 16'd5, 16'd0);
        @(negedge clk);
        clk_cyc();
        wrdata_en = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        clk_cyc();
        wrdata_en = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_inj", inj_cnt, 1);
        chk("t6_busy", busy, 0);
        clk_cyc();
        idle(5);
        chk("t6_no_clear", strobe_cnt - strobe_base, 1);

        // Abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        clk_cyc();
        abort = 1'b0;
        @(negedge clk);
        chk("t7_idle_busy", busy, 0);
        chk("t7_idle_done", done, 0);
        clk_cyc();
        idle(3);

        // cfg_valid while busy is ignored; latched count stays 2
        start_job(72'hAA << 64, 9'h100, 16'd2, 16'd0);
        @(negedge clk);
        chk("t7_we", fi_xor_we, 9'h100);
        chk("t7_wd", fi_xor_wrdata, 72'hAA << 64);
        clk_cyc();
        cfg_valid = 1'b1;
        cfg_count = 16'd1;
        wrdata_en = 1'b1;
        @(negedge clk);
        chk("t7_ready_busy", cfg_ready, 0);
        clk_cyc();
        cfg_valid = 1'b0;
        wrdata_en = 1'b0;
        @(negedge clk);
        chk("t7_still_busy", busy, 1);
        chk("t7_no_done", done, 0);
        chk("t7_inj", inj_cnt, 1);
        clk_cyc();
        abort = 1'b1;
        @(negedge clk);
        clk_cyc();
        abort = 1'b0;
        idle(3);

        // Reset during GAP: no CLEAR, everything back to reset values
        start_job(72'hF0, 9'h001, 16'd3, 16'd3);
        @(negedge clk);
        clk_cyc();
        wrdata_en = 1'b1;
        @(negedge clk);
        clk_cyc();
        wrdata_en = 1'b0;
        @(negedge clk);
        chk("t8_gap_busy", busy, 1);
        clk_cyc();
        rst = 1'b0;
        @(negedge clk);
        clk_cyc();
        strobe_base = strobe_cnt;
        @(negedge clk);
        chk("t8_we", fi_xor_we, 0);
        chk("t8_wd", fi_xor_wrdata, 0);
        chk("t8_busy", busy, 0);
        chk("t8_done", done, 0);
        chk("t8_inj", inj_cnt, 0);
        clk_cyc();
        rst = 1'b1;
        clk_cyc();
        @(negedge clk);
        chk("t8_ready", cfg_ready, 1);
        clk_cyc();
        idle(5);
        chk("t8_no_clear", strobe_cnt - strobe_base, 0);

        chk("invariants", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
